// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and the RV32M multiply/divide unit
interface muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    modport master (output start, flush, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, flush, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divider stays iterative).
module muldiv_unit (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
`ifdef MULDIV_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`endif
    state_t      state_q;
    logic [2:0]  op_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        neg_q;
    logic        rneg_q;
    logic        busy_q;
    logic        done_q;
    logic        sa;
    logic        sb;
    logic        div_special;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] special_res;
    logic [31:0] div_res;
    logic [31:0] fin;
    logic [32:0] dsh;
    logic [32:0] dif;
    logic [63:0] div_nx;
    logic [63:0] step;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fp;
`else
    logic [31:0] a_q;
    logic [32:0] msum;
    logic [63:0] mul_nx;
    logic [63:0] prod;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_comb begin
        sa = bus.op_a[31] & (bus.funct3[2] ? ~bus.funct3[0] : ~(bus.funct3[1] & bus.funct3[0]));
        sb = bus.op_b[31] & (bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1]);
        ma = sa ? -bus.op_a : bus.op_a;
        mb = sb ? -bus.op_b : bus.op_b;
        div_special = (bus.op_b == 32'd0) ||
                      (~bus.funct3[0] && bus.op_a == 32'h8000_0000 && bus.op_b == 32'hFFFF_FFFF);
        special_res = (bus.op_b == 32'd0) ? (bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF)
                                          : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);
        // restoring step: acc holds {partial remainder, dividend bits / quotient bits}
        dsh    = acc_q[63:31];
        dif    = dsh - {1'b0, b_q};
        div_nx = dif[32] ? {dsh[31:0], acc_q[30:0], 1'b0} : {dif[31:0], acc_q[30:0], 1'b1};
`ifdef MULDIV_FAST_MUL_EN
        fp   = {{32{sa}}, bus.op_a} * {{32{sb}}, bus.op_b};
        step = div_nx;
`else
        // shift-add step: acc holds {partial product high, remaining multiplier bits}
        msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        mul_nx = {msum, acc_q[31:1]};
        step   = (state_q == DIV) ? div_nx : mul_nx;
        prod   = neg_q ? -step : step;
`endif
        div_res = op_q[1] ? ((rneg_q & ~op_q[0]) ? -step[63:32] : step[63:32])
                          : ((neg_q & ~op_q[0]) ? -step[31:0] : step[31:0]);
`ifdef MULDIV_FAST_MUL_EN
        fin = op_q[2] ? div_res : 32'd0;
`else
        fin = op_q[2] ? div_res : ((op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
            a_q      <= 32'd0;
`endif
        end else if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.funct3;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        cnt_q  <= 5'd0;
                        b_q    <= mb;
                        if (bus.funct3[2]) begin
                            if (div_special) begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                result_q <= special_res;
                            end else begin
                                state_q <= DIV;
                                busy_q  <= 1'b1;
                                acc_q   <= {32'd0, ma};
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= (bus.funct3[1:0] == 2'b00) ? fp[31:0] : fp[63:32];
`else
                            state_q <= MUL;
                            busy_q  <= 1'b1;
                            a_q     <= ma;
                            acc_q   <= {32'd0, mb};
`endif
                        end
                    end
                end
                default: begin
                    acc_q <= step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random scoreboard bench for muldiv_unit (both MULDIV_FAST_MUL_EN builds)
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [31:0] sb_q[$];
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    always #5 clk = ~clk;

    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] as_;
        logic signed [31:0] bs_;
        as_ = a;
        bs_ = b;
        p = 64'd0;
        case (f)
            3'd0: p = {32'd0, a * b};
            3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'd2: p = {{32{a[31]}}, a} * {32'd0, b};
            3'd3: p = {32'd0, a} * {32'd0, b};
            default: ;
        endcase
        if (!f[2]) return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
        case (f[1:0])
            2'b00:   return 32'(as_ / bs_);
            2'b01:   return a / b;
            2'b10:   return 32'(as_ % bs_);
            default: return a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return ML;
        if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // n = cycle (1 = first after accept) in which done is seen; bc = busy cycles before it
    task automatic wait_done(output int n, output int bc);
        n = 1;
        bc = 0;
        while (bus.done !== 1'b1 && n < 80) begin
            if (bus.busy === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int bc;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct3 = ~f; bus.op_a = ~a; bus.op_b = b + 32'd1;
        wait_done(n, bc);
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy_cycles"}, bc, lat - 1);
        chk({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " result"}, bus.result, sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bc;
        logic saw;
        logic [2:0] f;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
        #12;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        issue("mul",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);
        issue("mulh",     3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, ML);
        issue("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);
        issue("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, ML);
        issue("div",      3'd4, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 33);
        issue("rem",      3'd6, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 33);
        issue("divu",     3'd5, 32'd20,        32'd6,         32'd3,         33);
        issue("div_by0",  3'd4, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1);
        issue("remu_by0", 3'd7, 32'd5,         32'd0,         32'd5,         1);
        issue("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            issue($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_op(f, a, b), lat_of(f, a, b));
        end

        // flush at cycle 10 of a DIV; result must still hold DIVU 20/6
        issue("pre_flush", 3'd5, 32'd20, 32'd6, 32'd3, 33);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'hFFFF_FFEC; bus.op_b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        saw = bus.done;
        repeat (9) begin
            @(posedge clk); #1;
            saw |= bus.done;
        end
        chk("flush busy_c10", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush busy_c11", {31'd0, bus.busy}, 32'd0);
        chk("flush no_done", {31'd0, saw | bus.done}, 32'd0);
        chk("flush result_kept", bus.result, 32'd3);
        issue("after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // async reset mid-DIV
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'hFFFF_FFEC; bus.op_b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid done", {31'd0, bus.done}, 32'd0);
        chk("rst_mid result", bus.result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // start held through DONE -> back-to-back issue
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd20; bus.op_b = 32'd6;
        @(posedge clk); #1;
        wait_done(n, bc);
        chk("b2b first latency", n, 33);
        chk("b2b first result", bus.result, 32'd3);
        bus.funct3 = 3'd4; bus.op_a = 32'hFFFF_FFEC; bus.op_b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b second busy", {31'd0, bus.busy}, 32'd1);
        wait_done(n, bc);
        chk("b2b done spacing", n, 33);
        chk("b2b second result", bus.result, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        chk("b2b done pulse", {31'd0, bus.done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit in the EX stage, beside the main ALU. The control path routes any R-type instruction with funct7 = 0000001 here instead of to the ALU control decode. The unit consumes funct3 as its operation code and runs a start/busy/done handshake; the pipeline stalls EX while `busy` is high. It returns the 32-bit result selected by the RV32M opcode.

## Interface
- No parameters (width fixed at 32).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only when the unit is in IDLE or DONE
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  32  rs1 value (multiplicand or dividend)
- `op_b`  in  32  rs2 value (multiplier or divisor)
- `flush`  in  1  synchronous abort from hazard/branch logic
- `busy`  out  1  high while an operation is iterating
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle
- `result`  out  32  registered result, held until the next accepted start

## Operation
- States: IDLE, MUL, DIV, DONE.
  - `busy` = 1 only in MUL and DIV.
  - `done` = 1 only in DONE.
- Accept: `start` && !`flush` in IDLE or DONE.
  - Latches `funct3`, the operand magnitudes and the result sign.
  - Iteration counter is set to 0.
- `start` in MUL or DIV is ignored; the requester holds it until `done`.
- MUL path (funct3[2] = 0):
  - Shift-add over operand magnitudes into a 64-bit accumulator, one bit per cycle, 32 cycles.
  - Signedness: MUL/MULH sign both operands; MULHSU signs a only; MULHU signs neither.
  - Sign correction is the two's-complement negate of the 64-bit product, applied on the transition to DONE.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- DIV path (funct3[2] = 1):
  - Restoring division of magnitudes, one quotient bit per cycle, 32 cycles.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Unsigned variants skip both corrections.
- Special cases are resolved at accept and go straight to DONE (1-cycle latency):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- DONE moves to IDLE next cycle unless a new start is accepted (back-to-back issue).
- `flush`:
  - From any state, goes to IDLE next edge.
  - No `done` pulse; `result` is unchanged.
  - `flush` overrides a simultaneous `start`.
- Reset (asynchronous, any time including mid-operation): state IDLE, `busy` 0, `done` 0, `result` 0, counter 0, accumulators 0.

## Timing
- Cycle 0: `start` accepted at the rising edge.
- Iterative op: `busy` high in cycles 1–32; `done` high in cycle 33; `busy` is low in cycle 33.
- Special-case op: `done` high in cycle 1; `busy` never asserts.
- `result` updates on the same edge that enters DONE.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Operands are captured at accept; later changes on `op_a`/`op_b` have no effect.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL-path ops compute a single-cycle 64-bit signed/unsigned product at accept and go straight to DONE (`done` in cycle 1, `busy` never asserts).
  - The MUL state and shift-add datapath are compiled out.
- Not defined: iterative 32-cycle multiply as above.
- The DIV path is identical in both builds.

## Test plan
- MUL: op_a = 7, op_b = −3 (0xFFFFFFFD) → result 0xFFFFFFEB. MULH on the same operands → 0xFFFFFFFF. `done` in cycle 33, or cycle 1 with `MULDIV_FAST_MUL_EN`.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU: op_a = 0xFFFFFFFF, op_b = 2 → 0xFFFFFFFF.
- DIV: −20 / 6 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFE. DIVU 20 / 6 → 3. Each gives `busy` in cycles 1–32 and `done` in cycle 33.
- Special cases:
  - DIV x / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000; REM on the same operands → 0.
  - Each gives `done` in cycle 1.
- Flush at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `result` keeps its previous value. A new start accepted at cycle 11 completes normally.
- Reset:
  - `rst_n` low mid-DIV → `busy`, `done` and `result` go to 0 immediately.
  - A `start` asserted during DONE is accepted, giving back-to-back `done` pulses 33 cycles apart.
